// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage integer pipeline.
// Shadows decode fields through ex/mem/wb to drive ALU operand muxes and stall.
module forward_hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_used,
  input  logic        dec_rs2_used,
  input  logic [4:0]  dec_rd,
  input  logic        dec_reg_write,
  input  logic        dec_mem_read,
  input  logic        flush,
  output logic [1:0]  select1,
  output logic [1:0]  select2,
  output logic        stall,
  output logic [15:0] stall_count
);

  localparam logic [1:0] SEL_REG    = 2'b00;
  localparam logic [1:0] SEL_ALUMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB  = 2'b10;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       valid;
  } shadow_t;

  shadow_t ex_q, mem_q, wb_q;
  shadow_t ex_d;

  logic hit1, hit2;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       used,
    input shadow_t    m,
    input shadow_t    w
  );
    logic [1:0] s;
    s = SEL_REG;
    // Loads in mem have no ALU result yet; they are covered by the stall.
    if (used && m.valid && m.reg_write && m.rd != 5'd0 &&
        m.rd == rs && !m.mem_read)
      s = SEL_ALUMEM;
    else if (used && w.valid && w.reg_write && w.rd != 5'd0 &&
             w.rd == rs)
      s = SEL_MEMWB;
    return s;
  endfunction

  always_comb begin
    hit1  = dec_rs1_used && (dec_rs1 == ex_q.rd);
    hit2  = dec_rs2_used && (dec_rs2 == ex_q.rd);
    stall = !flush && ex_q.valid && ex_q.mem_read &&
            (ex_q.rd != 5'd0) && (hit1 || hit2);
  end

  always_comb begin
    select1 = fwd_sel(ex_q.rs1, ex_q.rs1_used, mem_q, wb_q);
    select2 = fwd_sel(ex_q.rs2, ex_q.rs2_used, mem_q, wb_q);
  end

  always_comb begin
    ex_d = '0;
    if (!stall && !flush) begin
      ex_d.rs1       = dec_rs1;
      ex_d.rs2       = dec_rs2;
      ex_d.rs1_used  = dec_rs1_used;
      ex_d.rs2_used  = dec_rs2_used;
      ex_d.rd        = dec_rd;
      ex_d.reg_write = dec_reg_write;
      ex_d.mem_read  = dec_mem_read;
      ex_d.valid     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding selects,
// load-use stall, flush override, x0 handling and counter saturation.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_used, dec_rs2_used;
  logic        dec_reg_write, dec_mem_read, flush;
  logic [1:0]  select1, select2;
  logic        stall;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  forward_hazard_unit dut (
    .clk(clk), .rst(rst),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
    .dec_mem_read(dec_mem_read), .flush(flush),
    .select1(select1), .select2(select2),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic set_dec(input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic rw,
                         input logic mr);
    dec_rs1 = r1; dec_rs1_used = u1;
    dec_rs2 = r2; dec_rs2_used = u2;
    dec_rd = rd; dec_reg_write = rw; dec_mem_read = mr;
  endtask

  task automatic nop();
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    flush = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    set_dec(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1);
    repeat (2) step();
    n_checks++;
    if (stall !== 1'b0 || select1 !== 2'b00 || select2 !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b sel1=%b sel2=%b need 0/00/00",
               stall, select1, select2);
    end
    n_checks++;
    if (stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %h need 0000", stall_count);
    end
    nop();
    rst = 1'b0;
  endtask

  task automatic test_alu_mem_fwd();
    // add x5 ; sub x?, x5, x6 (first instruction after reset)
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_dec(5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_dep_no_stall: stall=%b need 0", stall);
    end
    step();
    n_checks++;
    if (select1 !== 2'b01 || select2 !== 2'b00 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_mem_fwd: sel1=%b sel2=%b stall=%b need 01/00/0",
               select1, select2, stall);
    end
    drain();
  endtask

  task automatic test_mem_wb_fwd();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    nop();
    step();
    set_dec(5'd3, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
    step();
    n_checks++;
    if (select2 !== 2'b10 || select1 !== 2'b00) begin
      n_fail++;
      $display("FAIL mem_wb_fwd: sel1=%b sel2=%b need 00/10",
               select1, select2);
    end
    drain();
  endtask

  task automatic test_priority();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_dec(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    set_dec(5'd5, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
    step();
    n_checks++;
    if (select1 !== 2'b01 || select2 !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_priority: sel1=%b sel2=%b need 01/01",
               select1, select2);
    end
    drain();
  endtask

  task automatic test_load_use();
    logic [15:0] c0;
    set_dec(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_dec(5'd7, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
    #1;
    c0 = stall_count;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_stall: stall=%b need 1", stall);
    end
    step();
    n_checks++;
    if (stall !== 1'b0 || stall_count !== c0 + 16'd1) begin
      n_fail++;
      $display("FAIL load_use_one_cycle: stall=%b cnt=%h need 0/%h",
               stall, stall_count, c0 + 16'd1);
    end
    step();
    n_checks++;
    if (select1 !== 2'b10 || select2 !== 2'b00 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_fwd: sel1=%b sel2=%b stall=%b need 10/00/0",
               select1, select2, stall);
    end
    drain();
  endtask

  task automatic test_x0();
    set_dec(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_no_stall: stall=%b need 0", stall);
    end
    step();
    step();
    n_checks++;
    if (select1 !== 2'b00 || select2 !== 2'b00) begin
      n_fail++;
      $display("FAIL x0_no_fwd_wb: sel1=%b sel2=%b need 00/00",
               select1, select2);
    end
    drain();
    // ALU writer of x0 must not forward either
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    step();
    set_dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    step();
    n_checks++;
    if (select1 !== 2'b00 || select2 !== 2'b00) begin
      n_fail++;
      $display("FAIL x0_no_fwd_mem: sel1=%b sel2=%b need 00/00",
               select1, select2);
    end
    drain();
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    set_dec(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_dec(5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    c0 = stall_count;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_overrides_stall: stall=%b need 0", stall);
    end
    step();
    flush = 1'b0;
    set_dec(5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    n_checks++;
    if (stall_count !== c0) begin
      n_fail++;
      $display("FAIL flush_count: got %h need %h", stall_count, c0);
    end
    step();
    // the flushed add x9 now sits in mem only if ex did not take a bubble
    n_checks++;
    if (select1 !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_bubble: sel1=%b need 00", select1);
    end
    drain();
  endtask

  task automatic test_saturate_reset();
    int bad;
    bad = 0;
    for (int i = 0; i < 65540; i++) begin
      set_dec(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      step();
      set_dec(5'd3, 1'b0, 5'd7, 1'b1, 5'd14, 1'b1, 1'b0);
      #1;
      if (stall !== 1'b1) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stall: %0d cycles without stall, need 0", bad);
    end
    n_checks++;
    if (stall_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL count_saturate: got %h need ffff", stall_count);
    end
    set_dec(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_dec(5'd7, 1'b1, 5'd7, 1'b1, 5'd14, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b1 || stall_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL pre_reset_stall: stall=%b cnt=%h need 1/ffff",
               stall, stall_count);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: stall=%b cnt=%h need 0/0000",
               stall, stall_count);
    end
    step();
    nop();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_mem_fwd();
    test_mem_wb_fwd();
    test_priority();
    test_load_use();
    test_x0();
    test_flush();
    test_saturate_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
